// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio convolution path
//
// Purpose: state encoding and bank/index geometry shared by the IR store and
// its consumer (the convolution engine).
// Ports: none (package).

package audio_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    LOADING   = 2'd1,
    ZERO_FILL = 2'd2,
    DONE      = 2'd3
  } ir_store_state_t;

  localparam int IR_BANKS   = 4;
  localparam int IR_INDEX_W = 13;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv - dual-port read-first block RAM
//
// Purpose: block RAM with a read/write port A and a read-only port B, each on
// its own clock. Port A returns the old contents on a write (read-first).
// Read data appears one clock after the address is presented.
// Ports:
//   clka/clkb   port clocks
//   ena/enb     port enables
//   wea         port A write enable
//   addra/addrb port addresses
//   dina        port A write data
//   douta/doutb registered read data

module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024
) (
  input  logic                         clka,
  input  logic                         clkb,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         wea,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) begin
        r_mem[addra] <= dina;
      end
      douta <= r_mem[addra];
    end
  end

  always_ff @(posedge clkb) begin
    if (enb) begin
      doutb <= r_mem[addrb];
    end
  end

endmodule

// File: rtl/impulse_response_store.sv
// rtl/impulse_response_store.sv - IR loader and 8-tap-per-cycle reader
//
// Purpose: accepts a streamed impulse response, writes it across four
// interleaved banks (bank k holds h[k*MEMORY_DEPTH + j] at offset j),
// zero-fills any unsent tail, then serves pipelined pairwise reads.
// Ports:
//   audio_clk, rst_in                 clock, async active-high reset
//   start_load                        pulse: drop current IR, begin new load
//   ir_sample_in/valid/last/ready     tap stream (valid/ready handshake)
//   impulse_in_memory_complete        all entries written, reads valid
//   load_count                        entries written so far (incl. zero fill)
//   first_ir_index, second_ir_index   bank offsets for even / odd outputs
//   ir_vals[0:7]                      taps, 2-cycle read latency

module impulse_response_store
  import audio_pkg::*;
#(
  parameter int IMPULSE_LENGTH = 24000,
  parameter int MEMORY_DEPTH   = IMPULSE_LENGTH >> 2
) (
  input  logic                         audio_clk,
  input  logic                         rst_in,
  input  logic                         start_load,
  input  logic signed [15:0]           ir_sample_in,
  input  logic                         ir_sample_valid,
  input  logic                         ir_sample_last,
  output logic                         ir_sample_ready,
  output logic                         impulse_in_memory_complete,
  output logic [15:0]                  load_count,
  input  logic [IR_INDEX_W-1:0]        first_ir_index,
  input  logic [IR_INDEX_W-1:0]        second_ir_index,
  output logic signed [15:0]           ir_vals [0:7]
);

  localparam int ADDR_W = $clog2(MEMORY_DEPTH);
  localparam int BANK_W = $clog2(IR_BANKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(IR_BANKS - 1);

  ir_store_state_t     r_state;
  logic                r_ready;
  logic                r_complete;
  logic [ADDR_W-1:0]   r_addr_ctr;
  logic [BANK_W-1:0]   r_bank_ctr;
  logic [15:0]         r_load_count;

  logic                w_wr_en;
  logic                w_last_entry;
  logic [15:0]         w_wr_data;
  logic [IR_BANKS-1:0] w_we;
  logic [ADDR_W-1:0]   w_addr_a;
  logic [ADDR_W-1:0]   w_addr_b;
  logic [15:0]         w_douta [IR_BANKS];
  logic [15:0]         w_doutb [IR_BANKS];

  // start_load has priority, so a tap offered alongside it is never written.
  assign w_wr_en = !start_load &&
                   (((r_state == LOADING) && ir_sample_valid && r_ready) ||
                    (r_state == ZERO_FILL));
  assign w_wr_data    = (r_state == LOADING) ? ir_sample_in : 16'sd0;
  assign w_last_entry = (r_bank_ctr == LAST_BANK) && (r_addr_ctr == LAST_ADDR);

  // Port A belongs to the write path until the load is complete.
  assign w_addr_a = r_complete ? first_ir_index[ADDR_W-1:0] : r_addr_ctr;
  assign w_addr_b = second_ir_index[ADDR_W-1:0];

  generate
    if (ADDR_W < IR_INDEX_W) begin : g_idx_high
      // Upper index bits are out of range by contract and carry no information.
      logic w_unused_idx;
      assign w_unused_idx = ^{first_ir_index[IR_INDEX_W-1:ADDR_W],
                              second_ir_index[IR_INDEX_W-1:ADDR_W]};
    end
  endgenerate

  always_comb begin
    w_we = '0;
    if (w_wr_en) begin
      w_we[r_bank_ctr] = 1'b1;
    end
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= EMPTY;
      r_ready      <= 1'b0;
      r_complete   <= 1'b0;
      r_addr_ctr   <= '0;
      r_bank_ctr   <= '0;
      r_load_count <= '0;
    end else if (start_load) begin
      r_state      <= LOADING;
      r_ready      <= 1'b1;
      r_complete   <= 1'b0;
      r_addr_ctr   <= '0;
      r_bank_ctr   <= '0;
      r_load_count <= '0;
    end else begin
      // Two counters walk offset then bank, avoiding a divide by MEMORY_DEPTH.
      if (w_wr_en) begin
        r_load_count <= r_load_count + 16'd1;
        if (r_addr_ctr == LAST_ADDR) begin
          r_addr_ctr <= '0;
          r_bank_ctr <= r_bank_ctr + BANK_W'(1);
        end else begin
          r_addr_ctr <= r_addr_ctr + ADDR_W'(1);
        end
      end
      case (r_state)
        EMPTY: begin
          r_ready <= 1'b0;
        end
        LOADING: begin
          if (w_wr_en) begin
            if (w_last_entry) begin
              r_state    <= DONE;
              r_ready    <= 1'b0;
              r_complete <= 1'b1;
            end else if (ir_sample_last) begin
              r_state <= ZERO_FILL;
              r_ready <= 1'b0;
            end
          end
        end
        ZERO_FILL: begin
          if (w_last_entry) begin
            r_state    <= DONE;
            r_complete <= 1'b1;
          end
        end
        DONE: begin
          r_ready    <= 1'b0;
          r_complete <= 1'b1;
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar b = 0; b < IR_BANKS; b++) begin : g_bank
      xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH (16),
        .RAM_DEPTH (MEMORY_DEPTH)
      ) u_bank (
        .clka  (audio_clk),
        .clkb  (audio_clk),
        .ena   (1'b1),
        .enb   (1'b1),
        .wea   (w_we[b]),
        .addra (w_addr_a),
        .addrb (w_addr_b),
        .dina  (w_wr_data),
        .douta (w_douta[b]),
        .doutb (w_doutb[b])
      );
    end
  endgenerate

  // Output register: second stage of the read pipeline, held at zero while
  // the store is not complete.
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < 8; k++) begin
        ir_vals[k] <= '0;
      end
    end else if (!r_complete || start_load) begin
      for (int k = 0; k < 8; k++) begin
        ir_vals[k] <= '0;
      end
    end else begin
      for (int k = 0; k < IR_BANKS; k++) begin
        ir_vals[2*k]   <= $signed(w_douta[k]);
        ir_vals[2*k+1] <= $signed(w_doutb[k]);
      end
    end
  end

  assign ir_sample_ready            = r_ready;
  assign impulse_in_memory_complete = r_complete;
  assign load_count                 = r_load_count;

endmodule

// File: tb/tb_impulse_response_store.sv
// tb/tb_impulse_response_store.sv - self-checking bench for impulse_response_store

module tb_impulse_response_store;

  localparam int IL = 16;
  localparam int MD = 4;

  logic               clk = 1'b0;
  logic               rst_in;
  logic               start_load;
  logic signed [15:0] ir_sample_in;
  logic               ir_sample_valid;
  logic               ir_sample_last;
  logic               ir_sample_ready;
  logic               complete;
  logic [15:0]        load_count;
  logic [12:0]        first_ir_index;
  logic [12:0]        second_ir_index;
  logic signed [15:0] ir_vals [0:7];

  impulse_response_store #(.IMPULSE_LENGTH(IL)) dut (
    .audio_clk                  (clk),
    .rst_in                     (rst_in),
    .start_load                 (start_load),
    .ir_sample_in               (ir_sample_in),
    .ir_sample_valid            (ir_sample_valid),
    .ir_sample_last             (ir_sample_last),
    .ir_sample_ready            (ir_sample_ready),
    .impulse_in_memory_complete (complete),
    .load_count                 (load_count),
    .first_ir_index             (first_ir_index),
    .second_ir_index            (second_ir_index),
    .ir_vals                    (ir_vals)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0]        first;
    logic [12:0]        second;
    logic signed [15:0] exp [8];
  } rd_t;

  int n_assert = 0;
  int n_fail   = 0;

  logic signed [15:0] tx    [IL];
  logic signed [15:0] model [IL];
  rd_t rd_q [$];
  rd_t sb_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rd_t model_vec(input int f, input int s);
    rd_t r;
    r.first  = 13'(f);
    r.second = 13'(s);
    for (int k = 0; k < 4; k++) begin
      r.exp[2*k]   = model[k*MD + f];
      r.exp[2*k+1] = model[k*MD + s];
    end
    return r;
  endfunction

  // Drive queued index pairs one per cycle; each expectation is checked two
  // clock edges after its pair is driven.
  task automatic run_reads(input string name);
    rd_t e;
    int  n;
    int  bad;
    n = rd_q.size();
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        first_ir_index  = rd_q[j].first;
        second_ir_index = rd_q[j].second;
        sb_q.push_back(rd_q[j]);
      end
      tick();
      if (j >= 1) begin
        e = sb_q.pop_front();
        bad = -1;
        for (int k = 7; k >= 0; k--) begin
          if (ir_vals[k] !== e.exp[k]) bad = k;
        end
        n_assert++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL %s[%0d] (first=%0d second=%0d) lane %0d: got %0d, expected %0d",
                   name, j - 1, e.first, e.second, bad, ir_vals[bad], e.exp[bad]);
        end
      end
    end
    rd_q.delete();
  endtask

  task automatic stream(input int n, input bit toggle, input bit use_last,
                        output int rdy_cycles, output int cmp_cycles);
    int  idx;
    int  cyc;
    bit  acc;
    idx = 0;
    cyc = 0;
    rdy_cycles = 0;
    cmp_cycles = 0;
    while (idx < n && cyc < 400) begin
      ir_sample_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      ir_sample_in    = tx[idx];
      ir_sample_last  = use_last && (idx == n - 1);
      if (ir_sample_ready) rdy_cycles++;
      if (complete) cmp_cycles++;
      acc = ir_sample_valid && ir_sample_ready;
      tick();
      if (acc) begin
        model[idx] = tx[idx];
        idx++;
      end
      cyc++;
    end
    chk("stream_taps_accepted", idx, n);
    ir_sample_valid = 1'b0;
    ir_sample_last  = 1'b0;
  endtask

  task automatic begin_load();
    for (int i = 0; i < IL; i++) model[i] = 16'sd0;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  rd_t full_tbl  [4];
  rd_t short_tbl [3];
  int  rdy;
  int  cmpc;
  int  cyc;
  int  nz;

  initial begin
    full_tbl[0].first = 1; full_tbl[0].second = 2;
    full_tbl[0].exp   = '{16'sd2, 16'sd3, 16'sd6, 16'sd7, 16'sd10, 16'sd11, 16'sd14, 16'sd15};
    full_tbl[1].first = 0; full_tbl[1].second = 3;
    full_tbl[1].exp   = '{16'sd1, 16'sd4, 16'sd5, 16'sd8, 16'sd9, 16'sd12, 16'sd13, 16'sd16};
    full_tbl[2].first = 3; full_tbl[2].second = 0;
    full_tbl[2].exp   = '{16'sd4, 16'sd1, 16'sd8, 16'sd5, 16'sd12, 16'sd9, 16'sd16, 16'sd13};
    full_tbl[3].first = 2; full_tbl[3].second = 2;
    full_tbl[3].exp   = '{16'sd3, 16'sd3, 16'sd7, 16'sd7, 16'sd11, 16'sd11, 16'sd15, 16'sd15};
    short_tbl[0].first = 0; short_tbl[0].second = 1;
    short_tbl[0].exp   = '{-16'sd100, -16'sd100, -16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    short_tbl[1].first = 3; short_tbl[1].second = 3;
    short_tbl[1].exp   = '{-16'sd100, -16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    short_tbl[2].first = 0; short_tbl[2].second = 0;
    short_tbl[2].exp   = '{-16'sd100, -16'sd100, -16'sd100, -16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0};

    rst_in = 1'b1; start_load = 1'b0;
    ir_sample_in = '0; ir_sample_valid = 1'b0; ir_sample_last = 1'b0;
    first_ir_index = '0; second_ir_index = '0;
    for (int i = 0; i < IL; i++) model[i] = 16'sd0;
    tick(); tick();
    rst_in = 1'b0;
    tick();

    // Reset state
    chk("reset_ready", int'(ir_sample_ready), 0);
    chk("reset_complete", int'(complete), 0);
    chk("reset_load_count", int'(load_count), 0);
    nz = 0;
    for (int k = 0; k < 8; k++) if (ir_vals[k] != 0) nz++;
    chk("reset_ir_vals_nonzero_lanes", nz, 0);

    // Full load h[n] = n+1
    for (int i = 0; i < IL; i++) tx[i] = 16'(i + 1);
    begin_load();
    chk("full_ready_after_start", int'(ir_sample_ready), 1);
    chk("full_count_after_start", int'(load_count), 0);
    stream(IL, 1'b0, 1'b1, rdy, cmpc);
    chk("full_ready_cycles", rdy, 16);
    chk("full_complete_early", cmpc, 0);
    chk("full_complete", int'(complete), 1);
    chk("full_load_count", int'(load_count), 16);
    chk("full_ready_low_done", int'(ir_sample_ready), 0);
    for (int i = 0; i < 4; i++) rd_q.push_back(full_tbl[i]);
    run_reads("full_tbl");

    // Taps offered in DONE are ignored
    ir_sample_valid = 1'b1; ir_sample_in = 16'sd555;
    tick(); tick();
    chk("done_ready_with_valid", int'(ir_sample_ready), 0);
    chk("done_count_with_valid", int'(load_count), 16);
    ir_sample_valid = 1'b0;

    // Pipelined sweep, one pair per cycle
    for (int f = 0; f < MD; f++) rd_q.push_back(model_vec(f, f));
    run_reads("pipe_sweep");

    // Short IR: five taps of -100 then zero fill
    for (int i = 0; i < IL; i++) tx[i] = -16'sd100;
    begin_load();
    stream(5, 1'b0, 1'b1, rdy, cmpc);
    chk("short_complete_after_last", int'(complete), 0);
    chk("short_count_after_last", int'(load_count), 5);
    chk("short_ready_zero_fill", int'(ir_sample_ready), 0);
    cyc = 0;
    while (!complete && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("short_zero_fill_cycles", cyc, 11);
    chk("short_load_count", int'(load_count), 16);
    for (int i = 0; i < 3; i++) rd_q.push_back(short_tbl[i]);
    run_reads("short_tbl");

    // Backpressure: valid toggles every cycle
    for (int i = 0; i < IL; i++) tx[i] = 16'(100 + 3 * i);
    begin_load();
    stream(IL, 1'b1, 1'b1, rdy, cmpc);
    chk("bp_complete", int'(complete), 1);
    chk("bp_load_count", int'(load_count), 16);
    for (int f = 0; f < MD; f++) rd_q.push_back(model_vec(f, MD - 1 - f));
    run_reads("bp_reads");

    // Restart mid-load; the tap presented with start_load must be dropped
    for (int i = 0; i < IL; i++) tx[i] = 16'(i + 1);
    begin_load();
    stream(7, 1'b0, 1'b0, rdy, cmpc);
    chk("restart_count_mid", int'(load_count), 7);
    for (int i = 0; i < IL; i++) model[i] = 16'sd0;
    start_load = 1'b1; ir_sample_valid = 1'b1; ir_sample_in = 16'sd777;
    tick();
    start_load = 1'b0; ir_sample_valid = 1'b0;
    chk("restart_count_cleared", int'(load_count), 0);
    chk("restart_complete_low", int'(complete), 0);
    for (int i = 0; i < IL; i++) tx[i] = 16'sd9;
    stream(IL, 1'b0, 1'b1, rdy, cmpc);
    chk("restart_complete_early", cmpc, 0);
    chk("restart_complete", int'(complete), 1);
    for (int f = 0; f < MD; f++) rd_q.push_back(model_vec(f, (f + 1) % MD));
    rd_q.push_back(model_vec(0, 0));
    run_reads("restart_reads");

    // Async reset while ir_vals is non-zero: clears with no clock edge
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_complete", int'(complete), 0);
    chk("async_rst_ready", int'(ir_sample_ready), 0);
    nz = 0;
    for (int k = 0; k < 8; k++) if (ir_vals[k] != 0) nz++;
    chk("async_rst_ir_vals_nonzero_lanes", nz, 0);
    tick();
    rst_in = 1'b0;
    tick();

    // Async reset mid-load
    begin_load();
    stream(5, 1'b0, 1'b0, rdy, cmpc);
    chk("midload_ready_before_rst", int'(ir_sample_ready), 1);
    #3;
    rst_in = 1'b1;
    #1;
    chk("midload_rst_ready", int'(ir_sample_ready), 0);
    chk("midload_rst_count", int'(load_count), 0);
    tick();
    rst_in = 1'b0;
    tick(); tick(); tick();
    chk("midload_ready_stays_low", int'(ir_sample_ready), 0);
    chk("midload_complete_low", int'(complete), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/impulse_response_store.md
Name: impulse_response_store

Overview:
- Producer side of the IR-memory interface used by the convolution engine.
- Accepts a streamed impulse response (valid/ready, 16-bit signed samples) and writes it into four interleaved BRAM banks, zero-filling any unsent tail.
- Asserts impulse_in_memory_complete once all entries are written.
- Afterwards serves pairwise index reads, returning eight IR taps per cycle on ir_vals.

Parameters:
- IMPULSE_LENGTH, 24000, total IR taps stored; must be a multiple of 4.
- MEMORY_DEPTH, IMPULSE_LENGTH>>2, entries per bank (6000 at default).

Ports:
- audio_clk  in  1  system audio clock.
- rst_in  in  1  asynchronous, active-high reset.
- start_load  in  1  one-cycle pulse: discard current IR and begin a new load.
- ir_sample_in  in  16  signed IR tap, in time order h[0], h[1], ...
- ir_sample_valid  in  1  ir_sample_in is valid.
- ir_sample_last  in  1  qualifies the final supplied tap (with valid).
- ir_sample_ready  out  1  store accepts a tap this cycle.
- impulse_in_memory_complete  out  1  all IMPULSE_LENGTH entries written; reads are valid.
- load_count  out  16  taps written so far, including zero-fill.
- first_ir_index  in  13  bank offset j for even taps, 0..MEMORY_DEPTH-1.
- second_ir_index  in  13  bank offset j for odd taps, 0..MEMORY_DEPTH-1.
- ir_vals  out  16x8 signed  ir_vals[2k]=h[k*MEMORY_DEPTH+first], ir_vals[2k+1]=h[k*MEMORY_DEPTH+second], k=0..3.

Behaviour:
- Reset values: complete=0, ready=0, load_count=0, ir_vals all 0, state=EMPTY. BRAM contents are not cleared.
- States:
  - EMPTY: ready=0. start_load -> LOADING; clear bank/addr/count.
  - LOADING: ready=1. On valid&&ready, write tap to bank[bank_ctr] at addr_ctr and increment load_count.
    - addr_ctr wraps MEMORY_DEPTH-1 -> 0 with bank_ctr+1. No divider; use two counters.
    - Write of entry IMPULSE_LENGTH-1 -> DONE. ir_sample_last is ignored on this write.
    - Otherwise, last on an accepted tap -> ZERO_FILL.
  - ZERO_FILL: ready=0. Writes 0 one entry per cycle until entry IMPULSE_LENGTH-1 is written, then -> DONE.
  - DONE: complete=1, ready=0. Further valid taps are ignored (ready stays low).
- start_load in any state (including mid-LOADING or ZERO_FILL):
  - Next cycle: state=LOADING, complete=0, counters=0.
  - A tap presented in the same cycle as start_load is not accepted.
- Read path, valid only in DONE:
  - Port A of each bank is addressed by first_ir_index; port B by second_ir_index.
  - Fixed latency 2 cycles (BRAM read plus output register): indices sampled at edge t appear on ir_vals after edge t+2.
  - One new index pair is accepted every cycle, fully pipelined.
- While complete=0, port A is owned by the write path and ir_vals is forced to 0 (output register cleared).
- Index >= MEMORY_DEPTH: behaviour undefined; the consumer guarantees range.
- Write port selection: only bank[bank_ctr] has we=1.

Decomposition:
- Shared package audio_pkg:
  - ir_store_state_t enum {EMPTY, LOADING, ZERO_FILL, DONE}.
  - IR_BANKS=4.
  - IR_INDEX_W=13.
- Memory: four instances of the existing xilinx_true_dual_port_read_first_2_clock_ram (RAM_WIDTH 16, RAM_DEPTH MEMORY_DEPTH). No new sub-module.

Test Plan (IMPULSE_LENGTH=16, MEMORY_DEPTH=4):
- Full load:
  - Stimulus: stream h[n]=n+1 with valid held high, last on n=15.
  - Response: ready high for 16 cycles; complete rises the cycle after the 16th write; load_count=16.
  - Read first=1, second=2 -> after 2 cycles ir_vals = {2,3,6,7,10,11,14,15} (index 0..7).
- Short IR:
  - Stimulus: stream 5 taps of -100, last on the 5th.
  - Response: ZERO_FILL for 11 cycles; complete asserts with load_count=16.
  - Read first=0, second=1 -> {-100,-100,-100,0,0,0,0,0}.
- Backpressure:
  - Stimulus: valid toggled 1,0,1,... across a full load.
  - Response: only taps with valid&&ready are written; final contents equal the contiguous sequence.
- Restart mid-load:
  - Stimulus: start_load after 7 taps, then a fresh 16-tap load of value 9.
  - Response: complete stays 0 until the new load finishes; all 16 entries read 9.
- Reset mid-load:
  - Stimulus: assert rst_in asynchronously between clock edges.
  - Response: complete=0, ready=0, ir_vals=0 immediately, without waiting for a clock edge; ready stays 0 until start_load.
- Pipelined reads:
  - Stimulus: after a full load, sweep first=0..3 and second=first, one pair per cycle.
  - Response: correct taps on consecutive cycles, each exactly 2 cycles behind its index.
